// File: rtl/pio_row_scan_pkg.sv
// Shared constants for the pio_row_scan output port: register map, CTRL/STATUS
// bit positions and the scan timer state encoding.
package pio_row_scan_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int CTRL_SCAN_EN      = 0;
    localparam int CTRL_INVERT       = 1;
    localparam int CTRL_IRQ_EN       = 2;
    localparam int STATUS_FRAME_DONE = 8;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/pio_row_scan_timer.sv
// Row scan timer: a PERIOD+1 clock divider stepping a row counter that wraps
// at WIDTH-1 and pulses o_frame_tick on the wrap; o_state exposes the FSM.
module pio_row_scan_timer
    import pio_row_scan_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DIV_W = 16,
    parameter int ROW_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_run,
    input  logic             i_restart,
    input  logic             i_div_clr,
    input  logic [DIV_W-1:0] i_period,
    output logic [ROW_W-1:0] o_row,
    output logic             o_frame_tick,
    output tmr_state_e       o_state
);

    tmr_state_e       r_state;
    tmr_state_e       w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_nxt;
    logic             w_frame_tick;
    logic             w_div_end;
    logic             w_row_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= TMR_IDLE;
            r_div   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_row   <= w_row_nxt;
        end
    end

    assign w_div_end = (r_div == i_period);
    assign w_row_end = (r_row == ROW_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_row_nxt    = r_row;
        w_frame_tick = 1'b0;

        case (r_state)
            TMR_IDLE: if (i_run)  w_state_nxt = TMR_RUN;
            TMR_RUN:  if (!i_run) w_state_nxt = TMR_IDLE;
            default:  w_state_nxt = TMR_IDLE;
        endcase

        // Counting starts on the same edge the FSM enters RUN, so the first
        // row is held for exactly PERIOD+1 clocks.
        if (w_state_nxt == TMR_IDLE || i_restart) begin
            w_div_nxt = '0;
            w_row_nxt = '0;
        end else if (i_div_clr) begin
            w_div_nxt = '0;
        end else if (w_div_end) begin
            w_div_nxt = '0;
            if (w_row_end) begin
                w_row_nxt    = '0;
                w_frame_tick = 1'b1;
            end else begin
                w_row_nxt = r_row + ROW_W'(1);
            end
        end else begin
            w_div_nxt = r_div + DIV_W'(1);
        end
    end

    assign o_row        = r_row;
    assign o_frame_tick = w_frame_tick;
    assign o_state      = r_state;

endmodule

// File: rtl/pio_row_scan.sv
// Avalon-MM output PIO with one-hot row scan for LED-matrix multiplexing.
// Define PIO_SCAN_IRQ_EN to build the FRAME_DONE flag, CTRL.IRQ_EN and irq.
module pio_row_scan
    import pio_row_scan_pkg::*;
#(
    parameter int               WIDTH    = 5,
    parameter int               DIV_W    = 16,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int ROW_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_data;
    logic             r_scan_en;
    logic             r_invert;
    logic [DIV_W-1:0] r_period;
    logic [WIDTH-1:0] r_out;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic             w_restart;
    logic             w_div_clr;
    logic [ROW_W-1:0] w_row;
    logic             w_frame_tick;
    tmr_state_e       w_tmr_state;
    logic             w_irq_en;
    logic             w_frame_done;
    logic [WIDTH-1:0] w_onehot;
    logic [WIDTH-1:0] w_out_src;
    logic             w_unused;

    assign w_wr = chipselect & ~write_n;
    assign w_wd = writedata[WIDTH-1:0];

    assign w_restart = w_wr && (address == ADDR_CTRL) &&
                       writedata[CTRL_SCAN_EN] && !r_scan_en;
    assign w_div_clr = w_wr && (address == ADDR_PERIOD) && r_scan_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= RST_DATA;
            r_scan_en <= 1'b0;
            r_invert  <= 1'b0;
            r_period  <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:   r_data   <= w_wd;
                ADDR_CTRL: begin
                    r_scan_en <= writedata[CTRL_SCAN_EN];
                    r_invert  <= writedata[CTRL_INVERT];
                end
                ADDR_PERIOD: r_period <= writedata[DIV_W-1:0];
                ADDR_OUTSET: r_data   <= r_data | w_wd;
                ADDR_OUTCLR: r_data   <= r_data & ~w_wd;
                default: ;
            endcase
        end
    end

`ifdef PIO_SCAN_IRQ_EN
    logic r_irq_en;
    logic r_frame_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
        end else if (w_wr && address == ADDR_CTRL) begin
            r_irq_en <= writedata[CTRL_IRQ_EN];
        end
    end

    // A frame completing in the same cycle as the W1C keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_done <= 1'b0;
        end else if (w_frame_tick) begin
            r_frame_done <= 1'b1;
        end else if (w_wr && address == ADDR_STATUS && writedata[STATUS_FRAME_DONE]) begin
            r_frame_done <= 1'b0;
        end
    end

    assign w_irq_en     = r_irq_en;
    assign w_frame_done = r_frame_done;
    assign irq          = r_frame_done & r_irq_en;
`else
    assign w_irq_en     = 1'b0;
    assign w_frame_done = 1'b0;
    assign irq          = 1'b0;
`endif

    pio_row_scan_timer #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W),
        .ROW_W (ROW_W)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_run        (r_scan_en),
        .i_restart    (w_restart),
        .i_div_clr    (w_div_clr),
        .i_period     (r_period),
        .o_row        (w_row),
        .o_frame_tick (w_frame_tick),
        .o_state      (w_tmr_state)
    );

    assign w_onehot  = {{(WIDTH-1){1'b0}}, 1'b1} << w_row;
    assign w_out_src = (r_scan_en ? w_onehot : r_data) ^ {WIDTH{r_invert}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= RST_DATA;
        end else begin
            r_out <= w_out_src;
        end
    end

    assign out_port = r_out;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(r_data);
            ADDR_CTRL: begin
                readdata[CTRL_SCAN_EN] = r_scan_en;
                readdata[CTRL_INVERT]  = r_invert;
                readdata[CTRL_IRQ_EN]  = w_irq_en;
            end
            ADDR_PERIOD: readdata = 32'(r_period);
            ADDR_STATUS: begin
                readdata[7:0]             = 8'(w_row);
                readdata[STATUS_FRAME_DONE] = w_frame_done;
            end
            default: ;
        endcase
    end

    // Upper write-data bits and the timer debug state have no consumer here.
    assign w_unused = ^{writedata, w_tmr_state, w_frame_tick};

endmodule

// File: tb/tb_pio_row_scan.sv
// Directed bench for pio_row_scan (WIDTH=5): register access, manual output,
// scan sequencing, frame-done interrupt, scan abort and asynchronous reset.
module tb_pio_row_scan;

    import pio_row_scan_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [4:0]  out_port;
    logic        irq;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_q[$];

    pio_row_scan dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input string tag, input logic [2:0] a,
                            input logic [31:0] mask, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(tag, readdata & mask, exp);
        chipselect = 1'b0;
    endtask

    task automatic scan_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, 32'(out_port), exp_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) bus_read($sformatf("rst_rd%0d", a), 3'(a), '1, 32'h0);

        // Manual mode with set/clear
        bus_write(ADDR_DATA, 32'h15);
        @(negedge clk);
        check("man_data", 32'(out_port), 32'h15);
        bus_write(ADDR_OUTSET, 32'h02);
        @(negedge clk);
        check("man_set", 32'(out_port), 32'h17);
        bus_write(ADDR_OUTCLR, 32'h04);
        @(negedge clk);
        check("man_clr", 32'(out_port), 32'h13);
        bus_read("rd_data", ADDR_DATA, '1, 32'h13);
        bus_read("rd_outset", ADDR_OUTSET, '1, 32'h0);
        bus_read("rd_outclr", ADDR_OUTCLR, '1, 32'h0);

        // Scan, PERIOD=3: each row held 4 clocks, wraps after row 4
        bus_write(ADDR_PERIOD, 32'd3);
        bus_write(ADDR_CTRL, 32'h1);
        for (int i = 0; i < 24; i++) exp_q.push_back(32'h1 << ((i / 4) % 5));
        scan_check("scan_p3", 24);
        bus_read("rd_period", ADDR_PERIOD, '1, 32'd3);
        bus_read("rd_ctrl", ADDR_CTRL, '1, 32'h1);

        // Scan + invert, PERIOD=0: advances every clock
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_PERIOD, 32'd0);
        bus_write(ADDR_CTRL, 32'h3);
        for (int i = 0; i < 10; i++) exp_q.push_back((32'h1 << (i % 5)) ^ 32'h1F);
        scan_check("scan_inv", 10);

        // Frame-done interrupt
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_STATUS, 32'h100);
        bus_write(ADDR_PERIOD, 32'd1);
        bus_write(ADDR_CTRL, 32'h5);
`ifdef PIO_SCAN_IRQ_EN
        repeat (9) @(negedge clk);
        check("irq_before", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'h1);
        bus_read("rd_ctrl_irq", ADDR_CTRL, '1, 32'h5);
        bus_write(ADDR_STATUS, 32'h100);
        check("irq_w1c", 32'(irq), 32'h0);
        repeat (6) @(negedge clk);
        bus_write(ADDR_STATUS, 32'h100);
        check("irq_set_wins", 32'(irq), 32'h1);
        bus_read("rd_status", ADDR_STATUS, 32'h1FF, 32'h100);
`else
        repeat (12) @(negedge clk);
        check("irq_tied", 32'(irq), 32'h0);
        bus_read("rd_ctrl_noirq", ADDR_CTRL, '1, 32'h1);
        bus_read("rd_status_hi", ADDR_STATUS, 32'hFFFF_FF00, 32'h0);
`endif

        // Abort scan mid-frame: back to DATA, row parked at 0
        bus_write(ADDR_CTRL, 32'h0);
        bus_write(ADDR_DATA, 32'h0A);
        bus_write(ADDR_PERIOD, 32'd1);
        bus_write(ADDR_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        check("abort_scan", 32'(out_port), 32'h02);
        bus_write(ADDR_CTRL, 32'h0);
        @(negedge clk);
        check("abort_out", 32'(out_port), 32'h0A);
        bus_read("abort_row", ADDR_STATUS, 32'hFF, 32'h0);

        // Asynchronous reset while scanning
        bus_write(ADDR_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst_out", 32'(out_port), 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        bus_read("arst_ctrl", ADDR_CTRL, '1, 32'h0);
        bus_read("arst_data", ADDR_DATA, '1, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read("arst_period", ADDR_PERIOD, '1, 32'h0);
        @(negedge clk);
        check("arst_idle", 32'(out_port), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
